// File: rtl/etapa_fetch.sv
// etapa_fetch: instruction-fetch stage (PC, imem address, IF/ID register).
// Define ETAPA_FETCH_PERF_EN to add the perf_fetched/perf_squashed counters.
module etapa_fetch #(
    parameter int                 ADDR_W   = 16,
    parameter int                 INSTR_W  = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0,
    parameter logic [INSTR_W-1:0] NOP_WORD = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               branch_take,
    input  logic [ADDR_W-1:0]  branch_target,
    input  logic               flush,
    input  logic               stall,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]  if_pc,
    output logic [3:0]         if_opcode,
    output logic               if_valid
`ifdef ETAPA_FETCH_PERF_EN
    ,
    output logic [15:0]        perf_fetched,
    output logic [15:0]        perf_squashed
`endif
);

    logic [ADDR_W-1:0]  pc_q;
    logic [ADDR_W-1:0]  rd_pc_q;
    logic               rd_valid_q;
    logic [INSTR_W-1:0] hold_data_q;
    logic               hold_vld_q;
    logic [INSTR_W-1:0] fetch_word;
    logic               load_valid;
    logic               load_bubble;

    // The memory keeps reading pc_q during a stall, so the word for
    // rd_pc_q is only on imem_rdata in the first stalled cycle; it is
    // parked in hold_data_q and used when the stall releases.
    assign fetch_word = hold_vld_q ? hold_data_q : imem_rdata;

    assign imem_addr = pc_q;
    assign if_opcode = if_instr[INSTR_W-1 -: 4];

    assign load_valid  = !rst && !flush && !stall && rd_valid_q;
    assign load_bubble = !rst && (flush || (!stall && !rd_valid_q));

    // Program counter: reset, redirect, hold, or sequential increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else if (branch_take) begin
            pc_q <= branch_target;
        end else if (!stall) begin
            pc_q <= pc_q + 1'b1;
        end
    end

    // Track which address the memory output belongs to and whether it
    // is on the correct path.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pc_q    <= RESET_PC;
            rd_valid_q <= 1'b0;
        end else if (branch_take) begin
            rd_pc_q    <= pc_q;
            rd_valid_q <= 1'b0;
        end else if (!stall) begin
            rd_pc_q    <= pc_q;
            rd_valid_q <= 1'b1;
        end
    end

    // Capture the pending memory word on the first stalled cycle.
    always_ff @(posedge clk) begin
        if (rst || branch_take || !stall) begin
            hold_vld_q  <= 1'b0;
            hold_data_q <= NOP_WORD;
        end else if (!hold_vld_q) begin
            hold_vld_q  <= 1'b1;
            hold_data_q <= imem_rdata;
        end
    end

    // IF/ID register: squash, hold, bubble, or load the fetched word.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            if_instr <= NOP_WORD;
            if_pc    <= '0;
            if_valid <= 1'b0;
        end else if (stall) begin
            if_instr <= if_instr;
            if_pc    <= if_pc;
            if_valid <= if_valid;
        end else if (!rd_valid_q) begin
            if_instr <= NOP_WORD;
            if_pc    <= '0;
            if_valid <= 1'b0;
        end else begin
            if_instr <= fetch_word;
            if_pc    <= rd_pc_q;
            if_valid <= 1'b1;
        end
    end

`ifdef ETAPA_FETCH_PERF_EN
    // Saturating counters of valid loads and bubble loads into IF/ID.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched  <= 16'd0;
            perf_squashed <= 16'd0;
        end else begin
            if (load_valid && perf_fetched != 16'hFFFF) begin
                perf_fetched <= perf_fetched + 16'd1;
            end
            if (load_bubble && perf_squashed != 16'hFFFF) begin
                perf_squashed <= perf_squashed + 16'd1;
            end
        end
    end
`else
    logic unused_perf;
    assign unused_perf = load_valid ^ load_bubble;
`endif

endmodule

// File: tb/tb_etapa_fetch.sv
// tb_etapa_fetch: directed test of the fetch stage against a
// synchronous memory holding mem[a] = 0x1000_0000 + a.
module tb_etapa_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        branch_take;
    logic [15:0] branch_target;
    logic        flush;
    logic        stall;
    logic [15:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] if_instr;
    logic [15:0] if_pc;
    logic [3:0]  if_opcode;
    logic        if_valid;

    logic [15:0] w_addr;
    logic [31:0] w_rdata;
    logic [31:0] w_instr;
    logic [15:0] w_pc;
    logic [3:0]  w_opcode;
    logic        w_valid;

`ifdef ETAPA_FETCH_PERF_EN
    logic [15:0] perf_fetched;
    logic [15:0] perf_squashed;
    logic [15:0] w_pf;
    logic [15:0] w_ps;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) imem_rdata <= 32'h1000_0000 + {16'h0, imem_addr};
    always @(posedge clk) w_rdata <= 32'h1000_0000 + {16'h0, w_addr};

    etapa_fetch u_dut (
        .clk           (clk),
        .rst           (rst),
        .branch_take   (branch_take),
        .branch_target (branch_target),
        .flush         (flush),
        .stall         (stall),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .if_instr      (if_instr),
        .if_pc         (if_pc),
        .if_opcode     (if_opcode),
        .if_valid      (if_valid)
`ifdef ETAPA_FETCH_PERF_EN
        ,
        .perf_fetched  (perf_fetched),
        .perf_squashed (perf_squashed)
`endif
    );

    etapa_fetch #(.RESET_PC(16'hFFFE)) u_wrap (
        .clk           (clk),
        .rst           (rst),
        .branch_take   (branch_take),
        .branch_target (branch_target),
        .flush         (flush),
        .stall         (stall),
        .imem_addr     (w_addr),
        .imem_rdata    (w_rdata),
        .if_instr      (w_instr),
        .if_pc         (w_pc),
        .if_opcode     (w_opcode),
        .if_valid      (w_valid)
`ifdef ETAPA_FETCH_PERF_EN
        ,
        .perf_fetched  (w_pf),
        .perf_squashed (w_ps)
`endif
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        branch_take = 1'b0;
        flush = 1'b0;
        stall = 1'b0;
        branch_target = 16'h0;
        step();
        step();
        checks++;
        if (imem_addr !== 16'h0000) begin
            errors++;
            $display("FAIL rst_addr got %h exp %h", imem_addr, 16'h0000);
        end
        checks++;
        if (if_instr !== 32'h0) begin
            errors++;
            $display("FAIL rst_instr got %h exp %h", if_instr, 32'h0);
        end
        checks++;
        if (if_pc !== 16'h0) begin
            errors++;
            $display("FAIL rst_pc got %h exp %h", if_pc, 16'h0);
        end
        checks++;
        if (if_opcode !== 4'h0) begin
            errors++;
            $display("FAIL rst_opcode got %h exp %h", if_opcode, 4'h0);
        end
        checks++;
        if (if_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_valid got %b exp 0", if_valid);
        end
        checks++;
        if (w_addr !== 16'hFFFE) begin
            errors++;
            $display("FAIL rst_wrap_addr got %h exp %h", w_addr, 16'hFFFE);
        end
    endtask

    task automatic test_fetch;
        logic [15:0] ea;
        logic [15:0] ew;
        logic [31:0] ei;
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            ea = 16'(c);
            ew = 16'hFFFE + 16'(c);
            checks++;
            if (imem_addr !== ea) begin
                errors++;
                $display("FAIL fetch_addr c%0d got %h exp %h", c, imem_addr, ea);
            end
            checks++;
            if (w_addr !== ew) begin
                errors++;
                $display("FAIL wrap_addr c%0d got %h exp %h", c, w_addr, ew);
            end
            checks++;
            if (if_valid !== (c >= 2)) begin
                errors++;
                $display("FAIL fetch_valid c%0d got %b exp %b", c, if_valid, c >= 2);
            end
            if (c >= 2) begin
                ei = 32'h1000_0000 + 32'(c - 2);
                checks++;
                if (if_pc !== 16'(c - 2)) begin
                    errors++;
                    $display("FAIL fetch_pc c%0d got %h exp %h", c, if_pc, 16'(c - 2));
                end
                checks++;
                if (if_instr !== ei) begin
                    errors++;
                    $display("FAIL fetch_instr c%0d got %h exp %h", c, if_instr, ei);
                end
                checks++;
                if (if_opcode !== 4'h1) begin
                    errors++;
                    $display("FAIL fetch_opcode c%0d got %h exp 1", c, if_opcode);
                end
            end
            if (c < 4) step();
        end
    endtask

    task automatic test_branch;
        step();
        branch_take = 1'b1;
        flush = 1'b1;
        branch_target = 16'h0040;
        step();
        branch_take = 1'b0;
        flush = 1'b0;
        checks++;
        if (imem_addr !== 16'h0040) begin
            errors++;
            $display("FAIL br_addr got %h exp %h", imem_addr, 16'h0040);
        end
        checks++;
        if (if_valid !== 1'b0) begin
            errors++;
            $display("FAIL br_bubble1 got %b exp 0", if_valid);
        end
        step();
        checks++;
        if (if_valid !== 1'b0) begin
            errors++;
            $display("FAIL br_bubble2 got %b exp 0", if_valid);
        end
        checks++;
        if (imem_addr !== 16'h0041) begin
            errors++;
            $display("FAIL br_addr2 got %h exp %h", imem_addr, 16'h0041);
        end
        step();
        checks++;
        if (if_valid !== 1'b1) begin
            errors++;
            $display("FAIL br_valid got %b exp 1", if_valid);
        end
        checks++;
        if (if_pc !== 16'h0040) begin
            errors++;
            $display("FAIL br_pc got %h exp %h", if_pc, 16'h0040);
        end
        checks++;
        if (if_instr !== 32'h1000_0040) begin
            errors++;
            $display("FAIL br_instr got %h exp %h", if_instr, 32'h1000_0040);
        end
`ifdef ETAPA_FETCH_PERF_EN
        checks++;
        if (perf_fetched !== 16'd5) begin
            errors++;
            $display("FAIL perf_fetched got %0d exp 5", perf_fetched);
        end
        checks++;
        if (perf_squashed !== 16'd3) begin
            errors++;
            $display("FAIL perf_squashed got %0d exp 3", perf_squashed);
        end
`endif
    endtask

    task automatic test_stall;
        logic [31:0] ei;
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (5) step();
        checks++;
        if (if_pc !== 16'h0003) begin
            errors++;
            $display("FAIL st_pre_pc got %h exp %h", if_pc, 16'h0003);
        end
        stall = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            if (k == 3) stall = 1'b0;
            checks++;
            if (imem_addr !== 16'h0005) begin
                errors++;
                $display("FAIL st_addr k%0d got %h exp %h", k, imem_addr, 16'h0005);
            end
            checks++;
            if (if_pc !== 16'h0003) begin
                errors++;
                $display("FAIL st_pc k%0d got %h exp %h", k, if_pc, 16'h0003);
            end
            checks++;
            if (if_instr !== 32'h1000_0003) begin
                errors++;
                $display("FAIL st_instr k%0d got %h exp %h", k, if_instr, 32'h1000_0003);
            end
        end
        for (int k = 0; k < 3; k++) begin
            step();
            ei = 32'h1000_0004 + 32'(k);
            checks++;
            if (if_pc !== 16'(4 + k) || if_valid !== 1'b1) begin
                errors++;
                $display("FAIL st_resume_pc k%0d got %h/%b exp %h/1", k, if_pc, if_valid, 16'(4 + k));
            end
            checks++;
            if (if_instr !== ei) begin
                errors++;
                $display("FAIL st_resume_instr k%0d got %h exp %h", k, if_instr, ei);
            end
            checks++;
            if (imem_addr !== 16'(6 + k)) begin
                errors++;
                $display("FAIL st_resume_addr k%0d got %h exp %h", k, imem_addr, 16'(6 + k));
            end
        end
    endtask

    task automatic test_stall_branch;
        stall = 1'b1;
        branch_take = 1'b1;
        flush = 1'b1;
        branch_target = 16'h0010;
        step();
        stall = 1'b0;
        branch_take = 1'b0;
        flush = 1'b0;
        checks++;
        if (imem_addr !== 16'h0010) begin
            errors++;
            $display("FAIL sb_addr got %h exp %h", imem_addr, 16'h0010);
        end
        checks++;
        if (if_valid !== 1'b0) begin
            errors++;
            $display("FAIL sb_squash got %b exp 0", if_valid);
        end
        step();
        checks++;
        if (if_valid !== 1'b0) begin
            errors++;
            $display("FAIL sb_bubble got %b exp 0", if_valid);
        end
        step();
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 16'h0010) begin
            errors++;
            $display("FAIL sb_pc got %h/%b exp %h/1", if_pc, if_valid, 16'h0010);
        end
        checks++;
        if (if_instr !== 32'h1000_0010) begin
            errors++;
            $display("FAIL sb_instr got %h exp %h", if_instr, 32'h1000_0010);
        end
    endtask

    task automatic test_flush_only;
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++;
        if (imem_addr !== 16'h0013) begin
            errors++;
            $display("FAIL fl_addr got %h exp %h", imem_addr, 16'h0013);
        end
        checks++;
        if (if_valid !== 1'b0) begin
            errors++;
            $display("FAIL fl_bubble got %b exp 0", if_valid);
        end
        step();
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 16'h0012) begin
            errors++;
            $display("FAIL fl_pc got %h/%b exp %h/1", if_pc, if_valid, 16'h0012);
        end
        checks++;
        if (if_instr !== 32'h1000_0012) begin
            errors++;
            $display("FAIL fl_instr got %h exp %h", if_instr, 32'h1000_0012);
        end
    endtask

    task automatic test_reset_mid_branch;
        branch_take = 1'b1;
        flush = 1'b1;
        branch_target = 16'h0080;
        step();
        branch_take = 1'b0;
        flush = 1'b0;
        stall = 1'b1;
        rst = 1'b1;
        step();
        checks++;
        if (imem_addr !== 16'h0000) begin
            errors++;
            $display("FAIL rmb_addr got %h exp %h", imem_addr, 16'h0000);
        end
        checks++;
        if (if_valid !== 1'b0 || if_pc !== 16'h0) begin
            errors++;
            $display("FAIL rmb_valid_pc got %b/%h exp 0/0000", if_valid, if_pc);
        end
        checks++;
        if (if_instr !== 32'h0 || if_opcode !== 4'h0) begin
            errors++;
            $display("FAIL rmb_instr got %h/%h exp 0/0", if_instr, if_opcode);
        end
        checks++;
        if (w_addr !== 16'hFFFE) begin
            errors++;
            $display("FAIL rmb_wrap_addr got %h exp %h", w_addr, 16'hFFFE);
        end
        stall = 1'b0;
        rst = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_branch();
        test_stall();
        test_stall_branch();
        test_flush_only();
        test_reset_mid_branch();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
